// File: rtl/mont_redc.sv
// mont_redc: bit-serial Montgomery reduction, y = x * 2^(-WIDTH) mod Q.
// Takes a signed residue in -Q..Q and returns a canonical value in 0..Q-1,
// retiring one bit of the Montgomery exponent per clock.
module mont_redc #(
    parameter int Q_M   = 8,
    parameter int Q_K   = 13,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int Q  = Q_K * (2 ** Q_M) + 1;
    localparam int AW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    // Q at accumulator width for the signed datapath, and at output width for the final fix-up
    localparam logic signed [AW-1:0] Q_ACC = AW'(Q);
    localparam logic [WIDTH-1:0]     Q_OUT = WIDTH'(Q);
    localparam logic [CW-1:0]        LAST  = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t                 state, state_next;
    logic signed [AW-1:0]   acc, acc_next, acc_sub;
    logic [CW-1:0]          cnt, cnt_next;
    logic [WIDTH-1:0]       data_next;
    logic                   valid_next;
    logic [WIDTH-1:0]       y;

    assign in_ready = (state == IDLE);

    // Next-state and datapath: halve acc modulo Q each RUN step, then fold into 0..Q-1
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        data_next  = out_data;
        valid_next = out_valid;
        acc_sub    = acc[0] ? (acc - Q_ACC) : acc;
        y          = acc[WIDTH-1:0];
        if (acc < 0) begin
            y = acc[WIDTH-1:0] + Q_OUT;
        end else if (acc == Q_ACC) begin
            y = '0;
        end
        case (state)
            IDLE: begin
                if (in_valid) begin
                    acc_next   = {in_data[WIDTH], in_data};
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                // Q is odd, so subtracting Q from an odd acc makes the shift exact
                acc_next = acc_sub >>> 1;
                cnt_next = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                data_next  = y;
                valid_next = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any operand in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
            out_data  <= data_next;
            out_valid <= valid_next;
        end
    end

endmodule

// File: tb/tb_mont_redc.sv
// tb_mont_redc: self-checking bench for mont_redc with a scoreboard model
// built from modular arithmetic, plus directed vectors with literal results.
module tb_mont_redc;

    localparam int Q_M   = 8;
    localparam int Q_K   = 13;
    localparam int WIDTH = 12;
    localparam int Q     = 3329;
    localparam int RINV  = 2704;
    localparam int LAT   = WIDTH + 1;
    localparam int ISSUE = WIDTH + 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    int assert_count = 0;
    int fail_count   = 0;
    int cyc          = 0;

    typedef struct {
        int y;
        int accept_edge;
    } exp_t;

    exp_t sb_q[$];
    int   acc_edges[$];

    mont_redc #(.Q_M(Q_M), .Q_K(Q_K), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // Clock generation
    always #5 clk = ~clk;

    // Edge counter used to time accepts and result arrival
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: multiply by the inverse of 2^WIDTH and normalise to 0..Q-1
    function automatic int ref_model(input int x);
        int r;
        r = (x * RINV) % Q;
        if (r < 0) r += Q;
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        assert_count++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Scoreboard: record accepts, compare every cycle a result is presented
    always @(negedge clk) begin : monitor
        static logic prev_valid = 1'b0;
        int xi;
        exp_t e;
        if (rst) begin
            sb_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                checkOutput("scoreboard depth", sb_q.size(), 1);
                checkOutput("out_data range", int'(out_data < Q), 1);
                checkOutput("in_ready while out_valid", in_ready, 0);
                if (sb_q.size() > 0) begin
                    checkOutput("out_data vs model", out_data, sb_q[0].y);
                    if (!prev_valid)
                        checkOutput("accept to out_valid latency", cyc - sb_q[0].accept_edge, LAT);
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
            prev_valid = out_valid;
            if (in_valid && in_ready) begin
                xi = int'($signed(in_data));
                e.y = ref_model(xi);
                e.accept_edge = cyc + 1;
                sb_q.push_back(e);
                acc_edges.push_back(cyc + 1);
            end
        end
    end

    // One directed transaction with a hand-computed expected result
    task automatic applyStimulus(input int x, input int exp_y, input string name);
        logic [WIDTH:0] xv;
        bit got;
        xv = x[WIDTH:0];
        checkOutput({name, " model pin"}, ref_model(x), exp_y);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = xv;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        checkOutput({name, " accepted"}, got, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) begin got = 1'b1; break; end
        end
        checkOutput({name, " result arrived"}, got, 1);
        checkOutput(name, out_data, exp_y);
        @(posedge clk); #1;
    endtask

    initial begin : stimulus
        int vals[4];
        int d;
        int x;
        bit got;
        bit done;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset in_ready", in_ready, 1);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_data", out_data, 0);
        @(posedge clk); #1;

        applyStimulus(767,   1,    "x=767");
        applyStimulus(0,     0,    "x=0");
        applyStimulus(1,     2704, "x=1");
        applyStimulus(-1,    625,  "x=-1");
        applyStimulus(3329,  0,    "x=Q");
        applyStimulus(-3329, 0,    "x=-Q");
        applyStimulus(-767,  3328, "x=-767");
        applyStimulus(3328,  625,  "x=Q-1");

        // Backpressure: result must hold and a stray in_valid must be dropped
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 13'd5;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        checkOutput("bp accepted", got, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) begin got = 1'b1; break; end
        end
        checkOutput("bp result arrived", got, 1);
        d = out_data;
        checkOutput("bp x=5", d, ref_model(5));
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 5) begin
                in_valid = 1'b1;
                in_data  = 13'd767;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            checkOutput("bp out_valid held", out_valid, 1);
            checkOutput("bp out_data stable", out_data, d);
            checkOutput("bp in_ready low", in_ready, 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("bp release out_valid", out_valid, 0);
        checkOutput("bp release in_ready", in_ready, 1);
        checkOutput("bp pulse dropped", sb_q.size(), 0);
        @(posedge clk); #1;

        // Back-to-back: in_valid held high with four queued values
        vals = '{100, -200, 3000, -3000};
        out_ready = 1'b1;
        acc_edges.delete();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            x = vals[k];
            in_data = x[WIDTH:0];
            got = 1'b0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (in_ready) begin got = 1'b1; break; end
            end
            checkOutput("b2b accepted", got, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!out_valid && in_ready) break;
        end
        checkOutput("b2b accept count", acc_edges.size(), 4);
        if (acc_edges.size() >= 4) begin
            for (int k = 1; k < 4; k++)
                checkOutput("b2b issue spacing", acc_edges[k] - acc_edges[k-1], ISSUE);
        end
        @(posedge clk); #1;

        // Reset during RUN step 5 discards the operand
        in_valid = 1'b1;
        in_data  = 13'd1234;
        got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        checkOutput("rst op accepted", got, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid-run reset in_ready", in_ready, 1);
        checkOutput("mid-run reset out_valid", out_valid, 0);
        checkOutput("mid-run reset out_data", out_data, 0);
        @(posedge clk); #1;
        applyStimulus(767, 1, "x=767 after reset");

        // Random operands in -Q..Q with random out_ready
        for (int n = 0; n < 2000; n++) begin
            x = int'($urandom_range(0, 2 * Q)) - Q;
            in_valid  = 1'b1;
            in_data   = x[WIDTH:0];
            out_ready = 1'($urandom_range(0, 1));
            done = 1'b0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                if (out_valid && out_ready) done = 1'b1;
                @(posedge clk); #1;
                if (!in_ready) in_valid = 1'b0;
                out_ready = 1'($urandom_range(0, 1));
                if (done) break;
            end
            if (!done) checkOutput("random op completed", done, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    // Watchdog so a stuck handshake can never hang the run
    initial begin : watchdog
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
